// File: rtl/monitor_pkg.sv
// Shared types and default widths for automaton monitor clusters.
// Record layout is {reports, offset}; clusters with other widths rebuild the same layout locally.
package monitor_pkg;

   localparam int MON_NUM_REPORTS = 4;
   localparam int MON_OFFSET_W    = 32;

   typedef struct packed {
      logic [MON_NUM_REPORTS-1:0] reports;
      logic [MON_OFFSET_W-1:0]    offset;
   } report_rec_t;

   localparam int MON_REC_W = $bits(report_rec_t);

endpackage

// File: rtl/monitor_report_collector_fifo.sv
// Generic synchronous FIFO, registered storage, head visible combinationally (0-cycle read).
// Push while full is accepted only alongside a pop; clear has priority over push/pop.
module report_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Empty head reads as zero so stale storage never leaks after a clear.
   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/monitor_report_collector.sv
// Tags non-empty monitor report vectors with their symbol offset and queues them for a valid/ready reader.
// Records appear 1 cycle after capture; when the queue is full and not draining, captures are dropped and counted.
module monitor_report_collector
   import monitor_pkg::*;
#(
   parameter int NUM_REPORTS = MON_NUM_REPORTS,
   parameter int OFFSET_W    = MON_OFFSET_W,
   parameter int DEPTH       = 8,
   parameter int DROP_W      = 16,
   parameter int EDGE_ONLY   = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clear,
   input  logic                      run,
   input  logic [NUM_REPORTS-1:0]    report_in,
   output logic                      rec_valid,
   input  logic                      rec_ready,
   output logic [NUM_REPORTS-1:0]    rec_reports,
   output logic [OFFSET_W-1:0]       rec_offset,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      overflow,
   output logic [DROP_W-1:0]         drop_count
);

   typedef struct packed {
      logic [NUM_REPORTS-1:0] reports;
      logic [OFFSET_W-1:0]    offset;
   } rec_t;

   logic [OFFSET_W-1:0]    offset_cnt;
   logic [NUM_REPORTS-1:0] prev_report;
   logic [NUM_REPORTS-1:0] cap;
   logic                   capture;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   push;
   logic                   drop;
   rec_t                   new_rec;
   rec_t                   head_rec;

   assign cap     = (EDGE_ONLY != 0) ? (report_in & ~prev_report) : report_in;
   assign capture = run && (cap != '0);
   assign pop     = !fifo_empty && rec_ready;
   assign push    = capture && (!fifo_full || pop);
   assign drop    = capture && fifo_full && !pop;

   assign new_rec.reports = cap;
   assign new_rec.offset  = offset_cnt;

   report_fifo #(
      .WIDTH ($bits(rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .push      (push),
      .push_data (new_rec),
      .pop       (pop),
      .head_data (head_rec),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign rec_valid   = !fifo_empty;
   assign rec_reports = head_rec.reports;
   assign rec_offset  = head_rec.offset;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         offset_cnt  <= '0;
         prev_report <= '0;
         overflow    <= 1'b0;
         drop_count  <= '0;
      end else if (clear) begin
         offset_cnt  <= '0;
         prev_report <= '0;
         overflow    <= 1'b0;
         drop_count  <= '0;
      end else begin
         if (run) begin
            offset_cnt  <= offset_cnt + OFFSET_W'(1);
            prev_report <= report_in;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_monitor_report_collector.sv
// Directed bench for monitor_report_collector: level-mode instance (DEPTH 8) and edge-mode instance (DEPTH 4).
// Expected records go into per-instance queues; a negedge monitor pops and compares on every accepted record.
module tb_monitor_report_collector;

   typedef struct packed {
      logic [3:0]  reports;
      logic [31:0] offset;
   } exp_rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        clear, run, rec_ready;
   logic [3:0]  report_in;
   logic        rec_valid, overflow;
   logic [3:0]  rec_reports;
   logic [31:0] rec_offset;
   logic [3:0]  fifo_level;
   logic [15:0] drop_count;

   logic        clear_e, run_e, ready_e;
   logic [3:0]  report_e;
   logic        valid_e, overflow_e;
   logic [3:0]  reports_e;
   logic [31:0] offset_e;
   logic [2:0]  level_e;
   logic [15:0] drop_e;

   exp_rec_t q_lvl[$];
   exp_rec_t q_edge[$];

   int checks   = 0;
   int failures = 0;

   monitor_report_collector #(
      .NUM_REPORTS(4), .OFFSET_W(32), .DEPTH(8), .DROP_W(16), .EDGE_ONLY(0)
   ) u_lvl (
      .clk(clk), .reset_n(reset_n), .clear(clear), .run(run), .report_in(report_in),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_reports(rec_reports),
      .rec_offset(rec_offset), .fifo_level(fifo_level), .overflow(overflow),
      .drop_count(drop_count)
   );

   monitor_report_collector #(
      .NUM_REPORTS(4), .OFFSET_W(32), .DEPTH(4), .DROP_W(16), .EDGE_ONLY(1)
   ) u_edge (
      .clk(clk), .reset_n(reset_n), .clear(clear_e), .run(run_e), .report_in(report_e),
      .rec_valid(valid_e), .rec_ready(ready_e), .rec_reports(reports_e),
      .rec_offset(offset_e), .fifo_level(level_e), .overflow(overflow_e),
      .drop_count(drop_e)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_rec_t e;
      forever begin
         @(negedge clk);
         if (rec_valid && rec_ready) begin
            if (q_lvl.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL lvl_unexpected: got offset %0d, expected no record", rec_offset);
            end else begin
               e = q_lvl.pop_front();
               chk("lvl_reports", 64'(rec_reports), 64'(e.reports));
               chk("lvl_offset", 64'(rec_offset), 64'(e.offset));
            end
         end
         if (valid_e && ready_e) begin
            if (q_edge.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL edge_unexpected: got offset %0d, expected no record", offset_e);
            end else begin
               e = q_edge.pop_front();
               chk("edge_reports", 64'(reports_e), 64'(e.reports));
               chk("edge_offset", 64'(offset_e), 64'(e.offset));
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; run = 1'b0; rec_ready = 1'b0; report_in = 4'b0;
      clear_e = 1'b0; run_e = 1'b0; ready_e = 1'b0; report_e = 4'b0;
      #23;
      chk("rst_valid", 64'(rec_valid), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_head", {28'd0, rec_reports, rec_offset}, 64'd0);
      step();
      reset_n = 1'b1;
      step();

      // Edge mode: held bits are recorded once; idle cycles do not refresh history.
      run_e = 1'b1;
      for (int i = 0; i < 4; i++) begin
         report_e = (i == 3) ? 4'b0111 : 4'b0011;
         if (i == 0) q_edge.push_back('{reports: 4'b0011, offset: 32'd0});
         if (i == 3) q_edge.push_back('{reports: 4'b0100, offset: 32'd3});
         step();
      end
      run_e = 1'b0; report_e = 4'b0000; step();
      run_e = 1'b1; report_e = 4'b0111; step();
      report_e = 4'b0001; step();
      report_e = 4'b0011; q_edge.push_back('{reports: 4'b0010, offset: 32'd6}); step();
      run_e = 1'b0;
      chk("edge_level", 64'(level_e), 64'd3);
      ready_e = 1'b1;
      repeat (3) step();
      ready_e = 1'b0;
      chk("edge_drained", 64'(level_e), 64'd0);

      // Basic tag
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         report_in = (i == 3) ? 4'b0100 : 4'b0000;
         if (i == 3) q_lvl.push_back('{reports: 4'b0100, offset: 32'd3});
         step();
         if (i == 2) chk("tag_not_yet", 64'(rec_valid), 64'd0);
         if (i == 3) begin
            chk("tag_valid", 64'(rec_valid), 64'd1);
            chk("tag_level", 64'(fifo_level), 64'd1);
         end
      end
      run = 1'b0;

      // Gating: reports without run are ignored and offset holds
      report_in = 4'b1111;
      repeat (3) step();
      chk("gate_level", 64'(fifo_level), 64'd1);
      report_in = 4'b0000; rec_ready = 1'b1; step(); rec_ready = 1'b0;
      run = 1'b1; report_in = 4'b0001; q_lvl.push_back('{reports: 4'b0001, offset: 32'd5}); step();
      run = 1'b0; rec_ready = 1'b1; step(); rec_ready = 1'b0;

      // Overflow after a clear restarts offsets at zero
      clear = 1'b1; step(); clear = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         report_in = 4'((i % 15) + 1);
         if (i < 8) q_lvl.push_back('{reports: 4'((i % 15) + 1), offset: 32'(i)});
         step();
      end
      run = 1'b0;
      chk("ovf_level", 64'(fifo_level), 64'd8);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_drop", 64'(drop_count), 64'd2);

      // Full with simultaneous pop and capture
      run = 1'b1; rec_ready = 1'b1; report_in = 4'b1010;
      q_lvl.push_back('{reports: 4'b1010, offset: 32'd10});
      step();
      run = 1'b0; rec_ready = 1'b0;
      chk("fullpop_level", 64'(fifo_level), 64'd8);
      chk("fullpop_drop", 64'(drop_count), 64'd2);
      rec_ready = 1'b1;
      repeat (8) step();
      rec_ready = 1'b0;
      chk("drain_level", 64'(fifo_level), 64'd0);
      chk("drain_valid", 64'(rec_valid), 64'd0);
      chk("drain_overflow_sticky", 64'(overflow), 64'd1);

      // Clear with 5 entries queued and a same-cycle capture
      run = 1'b1; report_in = 4'b0110;
      repeat (5) step();
      chk("pre_clear_level", 64'(fifo_level), 64'd5);
      clear = 1'b1; report_in = 4'b0001; step();
      clear = 1'b0; run = 1'b0;
      q_lvl.delete();
      chk("clr_valid", 64'(rec_valid), 64'd0);
      chk("clr_level", 64'(fifo_level), 64'd0);
      chk("clr_overflow", 64'(overflow), 64'd0);
      chk("clr_drop", 64'(drop_count), 64'd0);
      run = 1'b1; report_in = 4'b0010; q_lvl.push_back('{reports: 4'b0010, offset: 32'd0}); step();
      run = 1'b0;
      chk("clr_restart_level", 64'(fifo_level), 64'd1);

      // Async reset mid-burst, between clock edges
      run = 1'b1; report_in = 4'b0100;
      repeat (2) step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(rec_valid), 64'd0);
      chk("arst_level", 64'(fifo_level), 64'd0);
      chk("arst_head", {28'd0, rec_reports, rec_offset}, 64'd0);
      q_lvl.delete();
      run = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
      run = 1'b1; report_in = 4'b1000; q_lvl.push_back('{reports: 4'b1000, offset: 32'd0}); step();
      run = 1'b0; rec_ready = 1'b1; step(); step(); rec_ready = 1'b0;
      chk("final_level", 64'(fifo_level), 64'd0);

      chk("lvl_sb_empty", 64'(q_lvl.size()), 64'd0);
      chk("edge_sb_empty", 64'(q_edge.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
